pwm_multichannel: RTL and testbench

//   Multi-channel PWM audio DAC back end that replaces the single-channel pwm in the board tops.
//   One shared period counter drives CHANNELS comparators. Edge- or center-aligned mode.

---
 rtl/pwm_multichannel.sv | 136 +++++++++++++
 tb/tb_pwm_multichannel.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM back end: one shared period counter, per-channel comparators,
// double-buffered top/compare, complementary outputs with optional dead-time.
module pwm_multichannel #(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned WIDTH          = 9,
    parameter int unsigned DEADTIME       = 0,
    parameter int unsigned CENTER_ALIGNED = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [WIDTH-1:0]          i_top,
    input  logic                      i_top_valid,
    input  logic [CHANNELS*WIDTH-1:0] i_compare,
    input  logic [CHANNELS-1:0]       i_compare_valid,
    output logic [CHANNELS-1:0]       o_pwm,
    output logic [CHANNELS-1:0]       o_pwm_n,
    output logic                      o_cycle_end,
    output logic [WIDTH-1:0]          o_counter
);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    dir_t                dir, dir_nxt;
    logic [WIDTH-1:0]    counter, cnt_nxt;
    logic [WIDTH-1:0]    top_active, top_shadow, top_nxt;
    logic                cycle_end, cycle_end_nxt;
    logic [CHANNELS-1:0] raw;

    // cycle_end is registered, so it is derived from the next counter/top state
    always_comb begin
        top_nxt = top_active;
        cnt_nxt = counter;
        dir_nxt = dir;
        if (cycle_end)
            top_nxt = i_top_valid ? i_top : top_shadow;
        if (CENTER_ALIGNED == 0) begin
            dir_nxt = DIR_UP;
            cnt_nxt = cycle_end ? '0 : counter + WIDTH'(1);
        end else if (cycle_end) begin
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
        end else if (dir == DIR_UP) begin
            cnt_nxt = counter + WIDTH'(1);
            dir_nxt = (cnt_nxt == top_active) ? DIR_DOWN : DIR_UP;
        end else begin
            cnt_nxt = counter - WIDTH'(1);
            dir_nxt = DIR_DOWN;
        end
        if (CENTER_ALIGNED == 0)
            cycle_end_nxt = (cnt_nxt == top_nxt);
        else
            cycle_end_nxt = ((cnt_nxt == WIDTH'(1)) && (dir_nxt == DIR_DOWN)) || (top_nxt == '0);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            counter    <= '0;
            dir        <= DIR_UP;
            top_active <= '1;
            top_shadow <= '1;
            cycle_end  <= 1'b0;
        end else begin
            counter    <= cnt_nxt;
            dir        <= dir_nxt;
            top_active <= top_nxt;
            cycle_end  <= cycle_end_nxt;
            if (i_top_valid)
                top_shadow <= i_top;
        end
    end

    assign o_counter   = counter;
    assign o_cycle_end = cycle_end;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0] wr_val, cmp_active, cmp_shadow;
        logic             pwm_q, pwm_n_q;

        assign wr_val = i_compare[k*WIDTH +: WIDTH];

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                cmp_active <= '0;
                cmp_shadow <= '0;
            end else begin
                if (i_compare_valid[k])
                    cmp_shadow <= wr_val;
                if (cycle_end)
                    cmp_active <= i_compare_valid[k] ? wr_val : cmp_shadow;
            end
        end

        assign raw[k]     = (counter < cmp_active);
        assign o_pwm[k]   = pwm_q;
        assign o_pwm_n[k] = pwm_n_q;

        if (DEADTIME == 0) begin : g_nodt
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    pwm_q   <= 1'b0;
                    pwm_n_q <= 1'b0;
                end else begin
                    pwm_q   <= raw[k];
                    pwm_n_q <= ~raw[k];
                end
            end
        end else begin : g_dt
            localparam int unsigned DT_W = (DEADTIME < 2) ? 1 : $clog2(DEADTIME);
            logic [DT_W-1:0] dt_cnt;
            logic            raw_q;

            // Loading DEADTIME-1 on the change cycle gives a raw->assert latency of 1+DEADTIME
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    dt_cnt  <= '0;
                    raw_q   <= 1'b0;
                    pwm_q   <= 1'b0;
                    pwm_n_q <= 1'b0;
                end else if (raw[k] != raw_q) begin
                    raw_q   <= raw[k];
                    dt_cnt  <= DT_W'(DEADTIME - 1);
                    pwm_q   <= 1'b0;
                    pwm_n_q <= 1'b0;
                end else if (dt_cnt != '0) begin
                    dt_cnt  <= dt_cnt - DT_W'(1);
                    pwm_q   <= 1'b0;
                    pwm_n_q <= 1'b0;
                end else begin
                    pwm_q   <= raw_q;
                    pwm_n_q <= ~raw_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: edge-aligned, dead-time and center-aligned instances.
module tb_pwm_multichannel;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [8:0]  e_top, d_top, c_top;
    logic        e_top_v, d_top_v, c_top_v;
    logic [17:0] e_cmp, d_cmp, c_cmp;
    logic [1:0]  e_cmp_v, d_cmp_v, c_cmp_v;
    logic [1:0]  e_pwm, e_pwm_n, d_pwm, d_pwm_n, c_pwm, c_pwm_n;
    logic        e_ce, d_ce, c_ce;
    logic [8:0]  e_cnt, d_cnt, c_cnt;

    pwm_multichannel #(.CHANNELS(2), .WIDTH(9), .DEADTIME(0), .CENTER_ALIGNED(0)) u_edge (
        .i_clk(clk), .i_rst_n(rst_n), .i_top(e_top), .i_top_valid(e_top_v),
        .i_compare(e_cmp), .i_compare_valid(e_cmp_v), .o_pwm(e_pwm), .o_pwm_n(e_pwm_n),
        .o_cycle_end(e_ce), .o_counter(e_cnt));
    pwm_multichannel #(.CHANNELS(2), .WIDTH(9), .DEADTIME(2), .CENTER_ALIGNED(0)) u_dt (
        .i_clk(clk), .i_rst_n(rst_n), .i_top(d_top), .i_top_valid(d_top_v),
        .i_compare(d_cmp), .i_compare_valid(d_cmp_v), .o_pwm(d_pwm), .o_pwm_n(d_pwm_n),
        .o_cycle_end(d_ce), .o_counter(d_cnt));
    pwm_multichannel #(.CHANNELS(2), .WIDTH(9), .DEADTIME(0), .CENTER_ALIGNED(1)) u_ctr (
        .i_clk(clk), .i_rst_n(rst_n), .i_top(c_top), .i_top_valid(c_top_v),
        .i_compare(c_cmp), .i_compare_valid(c_cmp_v), .o_pwm(c_pwm), .o_pwm_n(c_pwm_n),
        .o_cycle_end(c_ce), .o_counter(c_cnt));

    int n_checks = 0;
    int n_errors = 0;

    int         m_period, m_hi0, m_n0, m_hi1, m_n1, m_ovl, m_both0, m_rise0;
    logic [8:0] m_cnt_ce, m_prev_cnt;

    typedef struct {
        logic [8:0] top;
        logic [8:0] c0;
        logic [8:0] c1;
        int         period;
        int         hi0;
        int         hi1;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic sample(input int sel, output logic [1:0] p, output logic [1:0] pn,
                          output logic ce, output logic [8:0] cnt);
        case (sel)
            0:       begin p = e_pwm; pn = e_pwm_n; ce = e_ce; cnt = e_cnt; end
            1:       begin p = d_pwm; pn = d_pwm_n; ce = d_ce; cnt = d_cnt; end
            default: begin p = c_pwm; pn = c_pwm_n; ce = c_ce; cnt = c_cnt; end
        endcase
    endtask

    // Drive shadow writes at a negedge, hold for one clock, then clear.
    task automatic set_regs(input int sel, input logic tv, input logic [8:0] top,
                            input logic [1:0] cv, input logic [8:0] c0, input logic [8:0] c1);
        case (sel)
            0:       begin e_top = top; e_top_v = tv; e_cmp = {c1, c0}; e_cmp_v = cv; end
            1:       begin d_top = top; d_top_v = tv; d_cmp = {c1, c0}; d_cmp_v = cv; end
            default: begin c_top = top; c_top_v = tv; c_cmp = {c1, c0}; c_cmp_v = cv; end
        endcase
        @(negedge clk);
        e_top_v = 1'b0; d_top_v = 1'b0; c_top_v = 1'b0;
        e_cmp_v = '0;   d_cmp_v = '0;   c_cmp_v = '0;
    endtask

    task automatic wait_ce(input int sel, input int budget, input string name, output int cycles);
        logic [1:0] p, pn;
        logic       ce;
        logic [8:0] cnt;
        cycles = 0;
        ce = 1'b0;
        while (!ce && cycles < budget) begin
            @(negedge clk);
            e_cmp_v = '0;
            cycles++;
            sample(sel, p, pn, ce, cnt);
        end
        if (!ce) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no cycle_end within %0d cycles", name, budget);
        end
    endtask

    // Entered at the negedge of a cycle_end cycle; measures one full period window.
    task automatic measure(input int sel, input int wr_at, input logic [8:0] wr_val);
        logic [1:0] p, pn;
        logic       ce, last_p0;
        logic [8:0] cnt;
        sample(sel, p, pn, ce, cnt);
        last_p0 = p[0];
        m_period = 0; m_hi0 = 0; m_n0 = 0; m_hi1 = 0; m_n1 = 0;
        m_ovl = 0; m_both0 = 0; m_rise0 = 0; m_cnt_ce = '0; m_prev_cnt = '0;
        ce = 1'b0;
        while (!ce && m_period < 2000) begin
            @(negedge clk);
            e_cmp_v = '0;
            sample(sel, p, pn, ce, cnt);
            m_period++;
            m_hi0 += int'(p[0]); m_n0 += int'(pn[0]);
            m_hi1 += int'(p[1]); m_n1 += int'(pn[1]);
            m_ovl += int'(p[0] & pn[0]) + int'(p[1] & pn[1]);
            m_both0 += int'(!p[0] && !pn[0]);
            m_rise0 += int'(p[0] && !last_p0);
            last_p0 = p[0];
            if (sel == 0 && int'(cnt) == wr_at) begin
                e_cmp[8:0] = wr_val;
                e_cmp_v    = 2'b01;
            end
            if (ce) m_cnt_ce = cnt;
            else    m_prev_cnt = cnt;
        end
        if (!ce) begin
            n_checks++;
            n_errors++;
            $display("FAIL measure: no period boundary within 2000 cycles");
        end
    endtask

    int cyc;
    int ok_cnt;
    logic [1:0] sp, spn;
    logic       sce;
    logic [8:0] scnt;

    initial begin
        vecs[0] = '{top: 9'd255, c0: 9'd128, c1: 9'd64,  period: 256, hi0: 128, hi1: 64};
        vecs[1] = '{top: 9'd255, c0: 9'd0,   c1: 9'd200, period: 256, hi0: 0,   hi1: 200};
        vecs[2] = '{top: 9'd255, c0: 9'd300, c1: 9'd10,  period: 256, hi0: 256, hi1: 10};
        vecs[3] = '{top: 9'd9,   c0: 9'd5,   c1: 9'd10,  period: 10,  hi0: 5,   hi1: 10};
        vecs[4] = '{top: 9'd0,   c0: 9'd1,   c1: 9'd0,   period: 1,   hi0: 1,   hi1: 0};

        rst_n = 1'b0;
        e_top = '0; d_top = '0; c_top = '0;
        e_top_v = 1'b0; d_top_v = 1'b0; c_top_v = 1'b0;
        e_cmp = '0; d_cmp = '0; c_cmp = '0;
        e_cmp_v = '0; d_cmp_v = '0; c_cmp_v = '0;
        repeat (3) @(negedge clk);

        // Reset state, then the first free-running cycle
        chk("rst_pwm",   int'({e_pwm, d_pwm, c_pwm}), 0);
        chk("rst_pwm_n", int'({e_pwm_n, d_pwm_n, c_pwm_n}), 0);
        chk("rst_ce",    int'({e_ce, d_ce, c_ce}), 0);
        chk("rst_cnt",   int'(e_cnt) + int'(d_cnt) + int'(c_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cnt",   int'(e_cnt), 1);
        chk("post_rst_pwm_n", int'(e_pwm_n), 3);
        chk("post_rst_pwm",   int'(e_pwm), 0);

        // Table: edge-aligned periods and duties, both channels
        foreach (vecs[i]) begin
            set_regs(0, 1'b1, vecs[i].top, 2'b11, vecs[i].c0, vecs[i].c1);
            wait_ce(0, 1200, "vec_ce1", cyc);
            wait_ce(0, 1200, "vec_ce2", cyc);
            measure(0, -1, '0);
            chk($sformatf("vec%0d_period", i), m_period, vecs[i].period);
            chk($sformatf("vec%0d_hi0", i), m_hi0, vecs[i].hi0);
            chk($sformatf("vec%0d_n0", i), m_n0, vecs[i].period - vecs[i].hi0);
            chk($sformatf("vec%0d_hi1", i), m_hi1, vecs[i].hi1);
            chk($sformatf("vec%0d_n1", i), m_n1, vecs[i].period - vecs[i].hi1);
            chk($sformatf("vec%0d_overlap", i), m_ovl, 0);
            chk($sformatf("vec%0d_ce_cnt", i), int'(m_cnt_ce), int'(vecs[i].top));
        end

        // Mid-period compare write waits for the boundary; a write in the boundary cycle applies at once
        set_regs(0, 1'b1, 9'd255, 2'b11, 9'd128, 9'd64);
        wait_ce(0, 600, "upd_ce1", cyc);
        wait_ce(0, 600, "upd_ce2", cyc);
        measure(0, 100, 9'd64);
        chk("upd_same_period", m_hi0, 128);
        measure(0, -1, '0);
        chk("upd_next_period", m_hi0, 64);
        e_cmp[8:0] = 9'd32;
        e_cmp_v    = 2'b01;
        measure(0, -1, '0);
        chk("upd_at_ce", m_hi0, 32);
        chk("upd_ch1_indep", m_hi1, 64);

        // Dead-time 2, top 19, cmp 10
        set_regs(1, 1'b1, 9'd19, 2'b11, 9'd10, 9'd0);
        wait_ce(1, 1200, "dt_ce1", cyc);
        wait_ce(1, 1200, "dt_ce2", cyc);
        measure(1, -1, '0);
        chk("dt_period", m_period, 20);
        chk("dt_hi0", m_hi0, 8);
        chk("dt_n0", m_n0, 8);
        chk("dt_gaps", m_both0, 4);
        chk("dt_rises", m_rise0, 1);
        chk("dt_overlap", m_ovl, 0);
        chk("dt_n1", m_n1, 20);
        set_regs(1, 1'b0, 9'd0, 2'b01, 9'd1, 9'd0);
        wait_ce(1, 100, "dt1_ce1", cyc);
        wait_ce(1, 100, "dt1_ce2", cyc);
        measure(1, -1, '0);
        chk("dt_swallow_hi0", m_hi0, 0);
        chk("dt_swallow_n0", m_n0, 17);

        // Center-aligned, top 8, cmp 4
        set_regs(2, 1'b1, 9'd8, 2'b01, 9'd4, 9'd0);
        wait_ce(2, 1200, "ctr_ce1", cyc);
        wait_ce(2, 1200, "ctr_ce2", cyc);
        measure(2, -1, '0);
        chk("ctr_period", m_period, 16);
        chk("ctr_hi0", m_hi0, 7);
        chk("ctr_n0", m_n0, 9);
        chk("ctr_ce_cnt", int'(m_cnt_ce), 1);
        chk("ctr_before_ce", int'(m_prev_cnt), 2);
        set_regs(2, 1'b1, 9'd0, 2'b00, 9'd0, 9'd0);
        wait_ce(2, 40, "ctr0_ce", cyc);
        ok_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (c_ce && c_cnt == 9'd0) ok_cnt++;
        end
        chk("ctr_top0_ce_every_clk", ok_cnt, 5);

        // Reset mid-period together with a top write: write must be discarded
        set_regs(0, 1'b1, 9'd255, 2'b01, 9'd128, 9'd64);
        wait_ce(0, 600, "rst2_ce", cyc);
        repeat (50) @(negedge clk);
        rst_n = 1'b0; e_top = 9'd50; e_top_v = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; e_top_v = 1'b0;
        sample(0, sp, spn, sce, scnt);
        chk("rst2_pwm", int'({sp, spn}), 0);
        chk("rst2_ce_cnt", int'({sce, scnt}), 0);
        wait_ce(0, 600, "rst2_first_ce", cyc);
        chk("rst2_first_period", cyc, 511);
        chk("rst2_ce_at", int'(e_cnt), 511);
        measure(0, -1, '0);
        chk("rst2_period", m_period, 512);
        chk("rst2_hi0", m_hi0, 0);
        chk("rst2_n0", m_n0, 512);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
